// File: rtl/apb_regbank_pkg.sv
// Shared definitions for the APB register bank: register offsets, scratch
// geometry, FSM state encoding and decoded register kinds.
package apb_regbank_pkg;

   localparam int ERRCNT_W    = 16;
   localparam int SCRATCH_N   = 16;

   localparam int OFS_ID      = 'h000;
   localparam int OFS_WAITCFG = 'h004;
   localparam int OFS_ERRCNT  = 'h008;
   localparam int OFS_SCRATCH = 'h010;

   typedef enum logic {
      ST_IDLE,
      ST_ACCESS
   } state_t;

   typedef enum logic [2:0] {
      REG_ID,
      REG_WAITCFG,
      REG_ERRCNT,
      REG_SCRATCH,
      REG_NONE
   } reg_t;

endpackage

// File: rtl/apb_regbank_regfile.sv
// 16x32 scratch storage with a byte-strobed write port and a
// combinational read port.
module apb_regbank_regfile
   import apb_regbank_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_we,
   input  logic [3:0]  i_widx,
   input  logic [3:0]  i_wstrb,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_ridx,
   output logic [31:0] o_rdata
);

   logic [31:0] r_mem [SCRATCH_N];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < SCRATCH_N; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wstrb[b]) begin
               r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/apb_regbank_slave.sv
// APB3/APB4 register bank slave: ID, wait-state config, saturating error
// counter and 16 scratch words. Responses are decoded from registered state only.
module apb_regbank_slave
   import apb_regbank_pkg::*;
#(
   parameter int          ADDRWIDTH    = 16,
   parameter logic [3:0]  WAIT_DEFAULT = 4'd0,
   parameter logic [31:0] ID_VALUE     = 32'hA5B2_0001
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_pclken,
   input  logic                 i_psel,
   input  logic                 i_penable,
   input  logic [ADDRWIDTH-1:0] i_paddr,
   input  logic                 i_pwrite,
   input  logic [31:0]          i_pwdata,
   input  logic [3:0]           i_pstrb,
   output logic                 o_pready,
   output logic                 o_pslverr,
   output logic [31:0]          o_prdata
);

   function automatic reg_t decode(input logic [ADDRWIDTH-1:0] a);
      reg_t k;
      k = REG_NONE;
      if (a[1:0] == 2'b00) begin
         if (a == ADDRWIDTH'(OFS_ID))           k = REG_ID;
         else if (a == ADDRWIDTH'(OFS_WAITCFG)) k = REG_WAITCFG;
         else if (a == ADDRWIDTH'(OFS_ERRCNT))  k = REG_ERRCNT;
         else if (a >= ADDRWIDTH'(OFS_SCRATCH) &&
                  a <  ADDRWIDTH'(OFS_SCRATCH + 4 * SCRATCH_N))
            k = REG_SCRATCH;
      end
      return k;
   endfunction

   state_t              r_state;
   state_t              w_state_nxt;
   logic [3:0]          r_cnt;
   logic [3:0]          r_waitcfg;
   logic [ERRCNT_W-1:0] r_errcnt;
   reg_t                r_kind;
   logic [3:0]          r_idx;
   logic                r_write;
   logic                r_err;
   logic [31:0]         r_wdata;
   logic [3:0]          r_strb;

   reg_t                w_kind;
   logic                w_err;
   logic                w_setup;
   logic                w_complete;
   logic                w_cnt_dec;
   logic                w_commit;
   logic                w_ready;
   logic [31:0]         w_scr_rdata;
   logic [31:0]         w_rdata;

   assign w_kind = decode(i_paddr);
   assign w_err  = (w_kind == REG_NONE) || (w_kind == REG_ID && i_pwrite);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Nothing moves unless the bridge's tick enable is high.
   always_comb begin
      w_state_nxt = r_state;
      w_setup     = 1'b0;
      w_complete  = 1'b0;
      w_cnt_dec   = 1'b0;
      if (i_pclken) begin
         case (r_state)
            ST_IDLE: begin
               if (i_psel && !i_penable) begin
                  w_setup     = 1'b1;
                  w_state_nxt = ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (!i_psel) begin
                  w_state_nxt = ST_IDLE;
               end else if (r_cnt != 4'd0) begin
                  w_cnt_dec = 1'b1;
               end else if (i_penable) begin
                  w_complete  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign w_commit = w_complete && r_write && !r_err;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt     <= '0;
         r_waitcfg <= WAIT_DEFAULT;
         r_errcnt  <= '0;
         r_kind    <= REG_NONE;
         r_idx     <= '0;
         r_write   <= 1'b0;
         r_err     <= 1'b0;
         r_wdata   <= '0;
         r_strb    <= '0;
      end else begin
         if (w_setup) begin
            r_kind  <= w_kind;
            r_idx   <= i_paddr[5:2] - 4'd4;
            r_write <= i_pwrite;
            r_err   <= w_err;
            r_wdata <= i_pwdata;
            r_strb  <= i_pstrb;
            r_cnt   <= r_waitcfg;
         end else if (w_cnt_dec) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_commit && r_kind == REG_WAITCFG) r_waitcfg <= r_wdata[3:0];
         // A clearing write and an error completion can never coincide.
         if (w_commit && r_kind == REG_ERRCNT) begin
            r_errcnt <= '0;
         end else if (w_complete && r_err && r_errcnt != '1) begin
            r_errcnt <= r_errcnt + 1'b1;
         end
      end
   end

   apb_regbank_regfile u_regfile (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (w_commit && r_kind == REG_SCRATCH),
      .i_widx  (r_idx),
      .i_wstrb (r_strb),
      .i_wdata (r_wdata),
      .i_ridx  (r_idx),
      .o_rdata (w_scr_rdata)
   );

   always_comb begin
      w_rdata = '0;
      case (r_kind)
         REG_ID:      w_rdata = ID_VALUE;
         REG_WAITCFG: w_rdata = {28'd0, r_waitcfg};
         REG_ERRCNT:  w_rdata = 32'(r_errcnt);
         REG_SCRATCH: w_rdata = w_scr_rdata;
         default:     w_rdata = '0;
      endcase
   end

   assign w_ready   = (r_state == ST_ACCESS) && (r_cnt == 4'd0);
   assign o_pready  = w_ready;
   assign o_pslverr = w_ready && r_err;
   assign o_prdata  = (w_ready && !r_err && !r_write) ? w_rdata : '0;

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Directed and randomized APB transfers against the register bank, checked
// against an address-map model of the registers.
module tb_apb_regbank_slave;

   localparam logic [31:0] ID_C = 32'hA5B2_0001;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_pclken;
   logic        i_psel;
   logic        i_penable;
   logic [15:0] i_paddr;
   logic        i_pwrite;
   logic [31:0] i_pwdata;
   logic [3:0]  i_pstrb;
   logic        o_pready;
   logic        o_pslverr;
   logic [31:0] o_prdata;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   int en_div = 1;
   int ph     = 0;

   // reference model state
   int          m_wait;
   int          m_errcnt;
   logic [31:0] m_scr [16];

   always #5 clk = ~clk;

   apb_regbank_slave #(
      .ADDRWIDTH    (16),
      .WAIT_DEFAULT (4'd0),
      .ID_VALUE     (ID_C)
   ) dut (
      .i_clk     (clk),
      .i_rst     (i_rst),
      .i_pclken  (i_pclken),
      .i_psel    (i_psel),
      .i_penable (i_penable),
      .i_paddr   (i_paddr),
      .i_pwrite  (i_pwrite),
      .i_pwdata  (i_pwdata),
      .i_pstrb   (i_pstrb),
      .o_pready  (o_pready),
      .o_pslverr (o_pslverr),
      .o_prdata  (o_prdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wait   = 0;
      m_errcnt = 0;
      for (int i = 0; i < 16; i++) m_scr[i] = '0;
   endtask

   // Applies one completed transfer to the model and returns the expected response.
   task automatic model_xfer(input logic [15:0] a, input logic w, input logic [31:0] wd,
                             input logic [3:0] st, output logic [31:0] erd, output logic eerr);
      int idx;
      erd  = '0;
      eerr = 1'b0;
      if (a % 4 != 0) eerr = 1'b1;
      else if (a == 0) begin
         if (w) eerr = 1'b1; else erd = ID_C;
      end else if (a == 4) begin
         if (w) m_wait = int'(wd % 16); else erd = 32'(m_wait);
      end else if (a == 8) begin
         if (w) m_errcnt = 0; else erd = 32'(m_errcnt);
      end else if (a >= 16 && a < 80) begin
         idx = (int'(a) - 16) / 4;
         if (w) begin
            for (int b = 0; b < 4; b++)
               if (st[b]) m_scr[idx][8*b +: 8] = wd[8*b +: 8];
         end else erd = m_scr[idx];
      end else eerr = 1'b1;
      if (eerr && m_errcnt < 65535) m_errcnt++;
   endtask

   // Advance to just after the next pclken-enabled edge; outputs must hold on skipped edges.
   task automatic tick();
      logic       en;
      logic       s_rdy, s_err;
      logic [31:0] s_rd;
      do begin
         en       = (ph == 0);
         i_pclken = en;
         ph       = (ph + 1 >= en_div) ? 0 : ph + 1;
         s_rdy = o_pready; s_err = o_pslverr; s_rd = o_prdata;
         @(posedge clk);
         #1;
         if (!en) begin
            check("stable_pready", {31'd0, o_pready}, {31'd0, s_rdy});
            check("stable_pslverr", {31'd0, o_pslverr}, {31'd0, s_err});
            check("stable_prdata", o_prdata, s_rd);
         end
      end while (!en);
   endtask

   task automatic xfer(input logic [15:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic er,
                       output int waits);
      logic got;
      i_psel = 1'b1; i_penable = 1'b0; i_paddr = a; i_pwrite = w; i_pwdata = wd; i_pstrb = st;
      tick();
      i_penable = 1'b1;
      waits = 0;
      got   = 1'b0;
      rd    = '0;
      er    = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         if (o_pready) begin
            got = 1'b1; rd = o_prdata; er = o_pslverr;
         end else waits++;
         tick();
      end
      i_psel = 1'b0; i_penable = 1'b0;
      check("xfer_done", {31'd0, got}, 32'd1);
   endtask

   task automatic run(input string tag, input logic [15:0] a, input logic w,
                      input logic [31:0] wd, input logic [3:0] st);
      logic [31:0] erd, rd;
      logic        eerr, er;
      int          ewait, waits;
      ewait = m_wait;
      model_xfer(a, w, wd, st, erd, eerr);
      xfer(a, w, wd, st, rd, er, waits);
      check({tag, "_pslverr"}, {31'd0, er}, {31'd0, eerr});
      check({tag, "_waits"}, 32'(waits), 32'(ewait));
      if (!w || eerr) check({tag, "_prdata"}, rd, erd);
      check({tag, "_pready_drop"}, {31'd0, o_pready}, 32'd0);
   endtask

   initial begin
      logic [15:0] a;
      int          sel;
      i_rst = 1'b1; i_pclken = 1'b0; i_psel = 1'b0; i_penable = 1'b0;
      i_paddr = '0; i_pwrite = 1'b0; i_pwdata = '0; i_pstrb = 4'hF;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_pready", {31'd0, o_pready}, 32'd0);
      check("rst_pslverr", {31'd0, o_pslverr}, 32'd0);
      check("rst_prdata", o_prdata, 32'd0);
      i_rst = 1'b0;
      @(posedge clk); #1;

      run("id_read", 16'h000, 1'b0, '0, 4'hF);
      run("wait_wr3", 16'h004, 1'b1, 32'd3, 4'hF);
      run("scr0_wr", 16'h010, 1'b1, 32'hDEAD_BEEF, 4'b0101);
      run("scr0_rd", 16'h010, 1'b0, '0, 4'hF);
      check("scr0_model", m_scr[0], 32'h00AD_00EF);

      run("err_unmapped", 16'h050, 1'b0, '0, 4'hF);
      run("err_id_wr", 16'h000, 1'b1, 32'h1234_5678, 4'hF);
      run("err_misalign", 16'h012, 1'b0, '0, 4'hF);
      run("errcnt_rd", 16'h008, 1'b0, '0, 4'hF);
      check("errcnt_model", 32'(m_errcnt), 32'd3);
      run("id_after_err", 16'h000, 1'b0, '0, 4'hF);

      en_div = 3; ph = 0;
      run("slow_wait_wr2", 16'h004, 1'b1, 32'd2, 4'hF);
      run("slow_scr0_rd", 16'h010, 1'b0, '0, 4'hF);
      en_div = 1; ph = 0;

      // Reset while a waited write to SCRATCH[1] is holding pready high.
      i_psel = 1'b1; i_penable = 1'b0; i_paddr = 16'h014; i_pwrite = 1'b1;
      i_pwdata = 32'hCAFE_F00D; i_pstrb = 4'hF;
      tick();
      i_penable = 1'b1;
      for (int k = 0; k < 10 && !o_pready; k++) tick();
      check("rst_mid_ready_before", {31'd0, o_pready}, 32'd1);
      #2 i_rst = 1'b1;
      #1;
      check("rst_mid_pready", {31'd0, o_pready}, 32'd0);
      check("rst_mid_pslverr", {31'd0, o_pslverr}, 32'd0);
      check("rst_mid_prdata", o_prdata, 32'd0);
      i_psel = 1'b0; i_penable = 1'b0;
      model_reset();
      @(posedge clk); #1;
      i_rst = 1'b0;
      @(posedge clk); #1;
      run("rst_scr1_rd", 16'h014, 1'b0, '0, 4'hF);
      run("rst_wait_rd", 16'h004, 1'b0, '0, 4'hF);

      // psel dropped during ACCESS must abort without side effects.
      run("abort_wait_wr1", 16'h004, 1'b1, 32'd1, 4'hF);
      run("abort_pre_err", 16'h100, 1'b0, '0, 4'hF);
      i_psel = 1'b1; i_penable = 1'b0; i_paddr = 16'h018; i_pwrite = 1'b1;
      i_pwdata = 32'h1111_2222; i_pstrb = 4'hF;
      tick();
      i_penable = 1'b1;
      tick();
      i_psel = 1'b0; i_penable = 1'b0;
      tick();
      check("abort_idle", {31'd0, o_pready}, 32'd0);
      run("abort_scr2_rd", 16'h018, 1'b0, '0, 4'hF);
      run("abort_errcnt_rd", 16'h008, 1'b0, '0, 4'hF);

      for (int n = 0; n < 60; n++) begin
         en_div = $urandom_range(1, 2); ph = 0;
         sel = $urandom_range(0, 9);
         case (sel)
            0: a = 16'h000;
            1: a = 16'h004;
            2: a = 16'h008;
            3: a = 16'h050 + 16'($urandom_range(0, 40) * 4);
            4: a = 16'h010 + 16'($urandom_range(0, 63));
            default: a = 16'h010 + 16'($urandom_range(0, 15) * 4);
         endcase
         if (a == 16'h004) run("rnd", a, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)), 4'hF);
         else run("rnd", a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/apb_regbank_slave.md
# apb_regbank_slave

APB3/APB4 slave register bank that sits directly downstream of the AHB-to-APB sync bridge and consumes its APB request (psel/penable/paddr/pwrite/pwdata/pstrb), qualified by the bridge's pclken. It provides an ID register, a programmable wait-state count, a saturating error counter and 16 byte-strobed scratch registers. Its pready/pslverr/prdata close the bridge's APB loop, so the bridge's wait-state and error paths can be exercised end to end.

## Interface
- ADDRWIDTH, 16, APB address width; must equal the bridge's `ADDRWIDTH
- WAIT_DEFAULT, 4'd0, reset value of WAITCFG
- ID_VALUE, 32'hA5B2_0001, read-only ID register contents

- clk  input  1  single clock; same clock as the bridge's HCLK
- rst  input  1  asynchronous, active-high reset
- pclken  input  1  APB tick enable from the bridge; all APB sampling and state changes occur only on clk edges with pclken=1
- psel  input  1  slave select
- penable  input  1  access phase
- paddr  input  ADDRWIDTH  byte address
- pwrite  input  1  1=write
- pwdata  input  32  write data
- pstrb  input  4  byte strobes; tie to 4'hF for APB3
- pready  output  1  transfer complete
- pslverr  output  1  error response, valid only with pready
- prdata  output  32  read data, valid only with pready on reads

## Operation
- Register map (word offsets, paddr[1:0] must be 0):
  - 0x000 ID: read-only, returns ID_VALUE
  - 0x004 WAITCFG: RW [3:0], upper bits read 0
  - 0x008 ERRCNT: RO [15:0], saturates at 16'hFFFF; any write clears it to 0 and returns OKAY
  - 0x010–0x04C SCRATCH[0..15]: RW, per-byte write under pstrb
- Error (pslverr=1, no state change, prdata=0) on: unmapped address, paddr[1:0]!=0, write to ID.
- ERRCNT increments by 1 on every completed error transfer; the error transfer that reaches saturation leaves it at FFFF.
- FSM, advances only on pclken ticks:
  - IDLE: on psel=1 & penable=0, latch paddr/pwrite/pwdata/pstrb, decode the error flag, load cnt<=WAITCFG, go to ACCESS.
  - ACCESS: pready = (cnt==0). If cnt!=0, cnt decrements. If cnt==0 and psel&penable, the transfer completes: write commits if no error, ERRCNT updates on error, go to IDLE.
  - In ACCESS, psel=0 (protocol violation) aborts to IDLE with no write and no ERRCNT change.
- pready, pslverr and prdata are decoded from registered state (FSM, cnt, latched address and error flag). They do not depend combinationally on APB inputs.
- A WAITCFG write takes effect from the next transfer's setup phase.

## Timing
- Reset: pready=0, pslverr=0, prdata=0, FSM=IDLE, cnt=0, WAITCFG=WAIT_DEFAULT, ERRCNT=0, SCRATCH=0.
- Reset asserted mid-transfer aborts the transfer: no write, and outputs go to 0 asynchronously.
- With WAITCFG=N, pready rises N pclken ticks after the access phase begins. The total transfer is N+2 ticks, counting setup.
- pready stays high until the completing tick, then drops the next clk edge. A setup for the next transfer is accepted on the first IDLE tick.
- With pclken=0, every register holds and outputs are stable.
- Write data is visible on a read issued in the very next transfer.

## Structure
- Package apb_regbank_pkg holds the register offset localparams, the SCRATCH base and count (16), the FSM state enum (IDLE, ACCESS), and the ERRCNT width (16).
- Sub-module apb_regbank_regfile holds the 16x32 scratch storage: byte-strobe write port and combinational read port.
- The top level keeps the FSM, wait counter, decode, WAITCFG and ERRCNT.

## Test plan
- Reset, then read 0x000 with WAITCFG=0 -> pready on the 2nd tick, prdata=A5B2_0001, pslverr=0.
- Write 0x004=3, then write 0x010=DEAD_BEEF with pstrb=4'b0101, then read 0x010 -> pready held low for 3 access ticks, prdata=00AD_00EF.
- Read 0x050, write 0x000, read 0x012 -> pslverr=1 each time, prdata=0, ERRCNT reads 3, ID unchanged.
- pclken=1 every 3rd clk, WAITCFG=2 -> pready asserts after exactly 2 enabled ticks, and all outputs are stable on non-enabled edges.
- Assert rst during a waited write to 0x014 -> outputs 0 immediately; SCRATCH[1] reads 0 and WAITCFG reads WAIT_DEFAULT after release.
- Drop psel during ACCESS on a write to 0x018 -> no write (reads 0), ERRCNT unchanged, and the next transfer completes normally.
